// File: rtl/uart_multiplier_pkg.sv
// Shared constants and state encodings for the UART-attached 64x64 multiplier.
package uart_multiplier_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 432;
    localparam int unsigned NBYTES               = 16;

    localparam logic UART_START = 1'b0;
    localparam logic UART_STOP  = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StRecv,
        StMul,
        StSend,
        StWaitAck
    } state_t;

    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_state_t;

endpackage

// File: rtl/uart_phy.sv
// 8N1 byte receiver (valid strobe plus framing-error flag) and byte transmitter.
module uart_phy
    import uart_multiplier_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_ferr,
    input  logic       i_tx_start,
    input  logic [7:0] i_tx_data,
    output logic       o_tx_ready,
    output logic       o_tx_busy,
    output logic       o_tx
);

    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);

    logic        r_rx_meta;
    logic        r_rx_sync;
    logic        r_rx_prev;
    rx_state_t   r_rx_state;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit_idx;
    logic [7:0]  r_rx_shift;
    logic        r_rx_valid;
    logic        r_rx_ferr;

    logic        r_tx_active;
    logic [9:0]  r_tx_frame;
    logic [3:0]  r_tx_bit_idx;
    logic [15:0] r_tx_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RxIdle;
            r_rx_cnt     <= '0;
            r_rx_bit_idx <= '0;
            r_rx_shift   <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_ferr    <= 1'b0;
        end else begin
            r_rx_meta  <= i_rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            unique case (r_rx_state)
                RxIdle: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RxStart;
                        r_rx_cnt   <= '0;
                    end
                end
                RxStart: begin
                    // A glitch that is high again at mid-bit is not a start bit.
                    if (r_rx_cnt == HALF_CNT) begin
                        r_rx_cnt     <= '0;
                        r_rx_bit_idx <= '0;
                        r_rx_state   <= r_rx_sync ? RxIdle : RxData;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                RxData: begin
                    if (r_rx_cnt == FULL_CNT) begin
                        r_rx_cnt     <= '0;
                        r_rx_shift   <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit_idx <= r_rx_bit_idx + 3'd1;
                        if (r_rx_bit_idx == 3'd7) begin
                            r_rx_state <= RxStop;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                RxStop: begin
                    if (r_rx_cnt == FULL_CNT) begin
                        r_rx_cnt   <= '0;
                        r_rx_valid <= 1'b1;
                        r_rx_ferr  <= (r_rx_sync != UART_STOP);
                        r_rx_state <= RxIdle;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 16'd1;
                    end
                end
                default: r_rx_state <= RxIdle;
            endcase
        end
    end

    assign o_rx_data  = r_rx_shift;
    assign o_rx_valid = r_rx_valid;
    assign o_rx_ferr  = r_rx_ferr;

    // Ready in the last clock of a stop bit so the next frame follows with no gap.
    assign o_tx_ready = !r_tx_active || (r_tx_cnt == FULL_CNT && r_tx_bit_idx == 4'd9);
    assign o_tx_busy  = r_tx_active;
    assign o_tx       = r_tx_active ? r_tx_frame[0] : UART_STOP;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_active  <= 1'b0;
            r_tx_frame   <= '1;
            r_tx_bit_idx <= '0;
            r_tx_cnt     <= '0;
        end else if (i_tx_start && o_tx_ready) begin
            r_tx_active  <= 1'b1;
            r_tx_frame   <= {UART_STOP, i_tx_data, UART_START};
            r_tx_bit_idx <= '0;
            r_tx_cnt     <= '0;
        end else if (r_tx_active) begin
            if (r_tx_cnt == FULL_CNT) begin
                r_tx_cnt <= '0;
                if (r_tx_bit_idx == 4'd9) begin
                    r_tx_active <= 1'b0;
                end else begin
                    r_tx_frame   <= {1'b1, r_tx_frame[9:1]};
                    r_tx_bit_idx <= r_tx_bit_idx + 4'd1;
                end
            end else begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/uart_multiplier.sv
// Receives a 16-byte operand block over UART, computes the 128-bit product A*B
// with a shift-add datapath and returns it over UART, then waits for the peer ack.
module uart_multiplier
    import uart_multiplier_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic CLK_IN,
    input  logic resetIn,
    input  logic UART_RX,
    input  logic RECEIVED_IN,
    output logic UART_TX,
    output logic RECEIVED_OUT
);

    logic [7:0] w_rx_data;
    logic       w_rx_valid;
    logic       w_rx_ferr;
    logic       w_rx_ok;
    logic       w_tx_start;
    logic [7:0] w_tx_data;
    logic       w_tx_ready;
    logic       w_tx_busy;

    state_t       r_state;
    logic [3:0]   r_byte_cnt;
    // Bytes 0..14 only; byte 15 goes straight into the multiplier register.
    logic [119:0] r_blk;
    logic [127:0] r_prod;
    logic [127:0] r_mcand;
    logic [63:0]  r_mplier;
    logic [5:0]   r_mul_cnt;
    logic [4:0]   r_send_idx;
    logic         r_received_out;

    uart_phy #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_phy (
        .i_clk      (CLK_IN),
        .i_rst_n    (resetIn),
        .i_rx       (UART_RX),
        .o_rx_data  (w_rx_data),
        .o_rx_valid (w_rx_valid),
        .o_rx_ferr  (w_rx_ferr),
        .i_tx_start (w_tx_start),
        .i_tx_data  (w_tx_data),
        .o_tx_ready (w_tx_ready),
        .o_tx_busy  (w_tx_busy),
        .o_tx       (UART_TX)
    );

    assign w_rx_ok      = w_rx_valid && !w_rx_ferr;
    assign w_tx_start   = (r_state == StSend) && !r_send_idx[4] && w_tx_ready;
    assign w_tx_data    = r_prod[{r_send_idx[3:0], 3'b000} +: 8];
    assign RECEIVED_OUT = r_received_out;

    always_ff @(posedge CLK_IN or negedge resetIn) begin
        if (!resetIn) begin
            r_state        <= StIdle;
            r_byte_cnt     <= '0;
            r_blk          <= '0;
            r_prod         <= '0;
            r_mcand        <= '0;
            r_mplier       <= '0;
            r_mul_cnt      <= '0;
            r_send_idx     <= '0;
            r_received_out <= 1'b0;
        end else begin
            r_received_out <= 1'b0;
            unique case (r_state)
                StIdle, StRecv: begin
                    if (w_rx_ok) begin
                        if (r_byte_cnt == 4'(NBYTES - 1)) begin
                            r_byte_cnt     <= '0;
                            r_received_out <= 1'b1;
                            r_state        <= StMul;
                            r_mul_cnt      <= '0;
                            r_prod         <= '0;
                            r_mcand        <= {64'd0, r_blk[63:0]};
                            r_mplier       <= {w_rx_data, r_blk[119:64]};
                        end else begin
                            r_blk[{r_byte_cnt, 3'b000} +: 8] <= w_rx_data;
                            r_byte_cnt <= r_byte_cnt + 4'd1;
                            r_state    <= StRecv;
                        end
                    end
                end
                StMul: begin
                    if (r_mplier[0]) begin
                        r_prod <= r_prod + r_mcand;
                    end
                    r_mcand   <= r_mcand << 1;
                    r_mplier  <= r_mplier >> 1;
                    r_mul_cnt <= r_mul_cnt + 6'd1;
                    if (r_mul_cnt == 6'd63) begin
                        r_state    <= StSend;
                        r_send_idx <= '0;
                    end
                end
                StSend: begin
                    if (!r_send_idx[4]) begin
                        if (w_tx_ready) begin
                            r_send_idx <= r_send_idx + 5'd1;
                        end
                    end else if (!w_tx_busy) begin
                        r_state <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (RECEIVED_IN) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_multiplier.sv
// Bench for uart_multiplier: serial operand blocks in, serial products checked
// against 128-bit arithmetic, plus framing, reset and acknowledge scenarios.
module tb_uart_multiplier;

    localparam int CPB = 8;

    logic CLK_IN = 1'b0;
    logic resetIn = 1'b0;
    logic UART_RX = 1'b1;
    logic RECEIVED_IN = 1'b1;
    logic UART_TX;
    logic RECEIVED_OUT;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int pulse_cnt = 0;
    int pulse_cyc = 0;
    int tx_low_cnt = 0;

    uart_multiplier #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .CLK_IN       (CLK_IN),
        .resetIn      (resetIn),
        .UART_RX      (UART_RX),
        .RECEIVED_IN  (RECEIVED_IN),
        .UART_TX      (UART_TX),
        .RECEIVED_OUT (RECEIVED_OUT)
    );

    always #5 CLK_IN = ~CLK_IN;

    always @(posedge CLK_IN) cyc <= cyc + 1;

    always @(negedge CLK_IN) begin
        if (RECEIVED_OUT === 1'b1) begin
            pulse_cnt <= pulse_cnt + 1;
            pulse_cyc <= cyc;
        end
        if (UART_TX === 1'b0) tx_low_cnt <= tx_low_cnt + 1;
    end

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        UART_RX = 1'b0;
        repeat (CPB) @(negedge CLK_IN);
        for (int i = 0; i < 8; i++) begin
            UART_RX = d[i];
            repeat (CPB) @(negedge CLK_IN);
        end
        UART_RX = stop_bit;
        repeat (CPB) @(negedge CLK_IN);
        UART_RX = 1'b1;
    endtask

    task automatic send_block(input logic [127:0] blk);
        for (int k = 0; k < 16; k++) send_byte(blk[8*k +: 8], 1'b1);
    endtask

    // Waits (bounded) for the first start bit, then samples 16 back-to-back frames.
    task automatic recv_block(output logic [127:0] p, output bit ok, output int lat);
        int budget;
        p = '0;
        ok = 1'b1;
        lat = -1;
        budget = 0;
        while (UART_TX !== 1'b0 && budget < 2000) begin
            @(negedge CLK_IN);
            budget++;
        end
        if (UART_TX !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        lat = cyc - pulse_cyc;
        repeat (CPB / 2) @(negedge CLK_IN);
        for (int k = 0; k < 16; k++) begin
            if (UART_TX !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge CLK_IN);
                p[8*k + i] = UART_TX;
            end
            repeat (CPB) @(negedge CLK_IN);
            if (UART_TX !== 1'b1) ok = 1'b0;
            if (k < 15) repeat (CPB) @(negedge CLK_IN);
        end
    endtask

    task automatic run_block(input logic [63:0] a, input logic [63:0] b, input string name);
        logic [127:0] got;
        logic [127:0] exp;
        bit ok;
        int lat;
        int p0;
        exp = {64'd0, a} * {64'd0, b};
        p0 = pulse_cnt;
        send_block({b, a});
        recv_block(got, ok, lat);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s frames: got malformed or missing reply, want 16 framed bytes", name);
        end
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s product: got %h want %h", name, got, exp);
        end
        total++;
        if (pulse_cnt - p0 != 1) begin
            bad++;
            $display("FAIL %s received_out: got %0d pulses want 1", name, pulse_cnt - p0);
        end
        total++;
        if (lat < 64 || lat > 66) begin
            bad++;
            $display("FAIL %s latency: got %0d want 65+/-1", name, lat);
        end
        repeat (CPB * 2) @(negedge CLK_IN);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK_IN);
        total++;
        if (UART_TX !== 1'b1) begin
            bad++;
            $display("FAIL reset_tx: got %b want 1", UART_TX);
        end
        total++;
        if (RECEIVED_OUT !== 1'b0) begin
            bad++;
            $display("FAIL reset_rcv: got %b want 0", RECEIVED_OUT);
        end
        resetIn = 1'b1;
        repeat (CPB * 4) @(negedge CLK_IN);
        total++;
        if (UART_TX !== 1'b1) begin
            bad++;
            $display("FAIL idle_tx: got %b want 1", UART_TX);
        end
        total++;
        if (pulse_cnt != 0) begin
            bad++;
            $display("FAIL idle_rcv: got %0d pulses want 0", pulse_cnt);
        end
    endtask

    task automatic test_patterns();
        run_block(64'hFF00FF00FF00FF00, 64'hFF00FF00FF00FF00, "ff00");
        run_block(64'd3, 64'd5, "three_five");
        run_block(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, "max");
        run_block(64'd0, {$urandom, $urandom}, "zero_a");
    endtask

    task automatic test_random();
        for (int n = 0; n < 2; n++) begin
            run_block({$urandom, $urandom}, {$urandom, $urandom}, "random");
        end
    endtask

    task automatic test_framing();
        send_byte(8'hA5, 1'b0);
        repeat (CPB * 2) @(negedge CLK_IN);
        run_block({$urandom, $urandom}, {$urandom, $urandom}, "framing");
    endtask

    task automatic test_reset_mid_block();
        logic [127:0] blk;
        int p0;
        blk = {$urandom, $urandom, $urandom, $urandom};
        p0 = pulse_cnt;
        for (int k = 0; k < 9; k++) send_byte(blk[8*k +: 8], 1'b1);
        UART_RX = 1'b0;
        repeat (CPB * 4) @(negedge CLK_IN);
        resetIn = 1'b0;
        repeat (3) @(negedge CLK_IN);
        UART_RX = 1'b1;
        resetIn = 1'b1;
        repeat (CPB * 2) @(negedge CLK_IN);
        total++;
        if (pulse_cnt != p0) begin
            bad++;
            $display("FAIL abort_rcv: got %0d pulses want 0", pulse_cnt - p0);
        end
        run_block({$urandom, $urandom}, {$urandom, $urandom}, "after_abort");
    endtask

    task automatic test_wait_ack();
        int p0;
        int l0;
        RECEIVED_IN = 1'b0;
        run_block({$urandom, $urandom}, {$urandom, $urandom}, "ack_low");
        repeat (CPB * 2) @(negedge CLK_IN);
        p0 = pulse_cnt;
        l0 = tx_low_cnt;
        send_block({$urandom, $urandom, $urandom, $urandom});
        repeat (CPB * 20) @(negedge CLK_IN);
        total++;
        if (pulse_cnt != p0) begin
            bad++;
            $display("FAIL ack_hold_rcv: got %0d pulses want 0", pulse_cnt - p0);
        end
        total++;
        if (tx_low_cnt != l0) begin
            bad++;
            $display("FAIL ack_hold_tx: got %0d low cycles want 0", tx_low_cnt - l0);
        end
        RECEIVED_IN = 1'b1;
        repeat (4) @(negedge CLK_IN);
        run_block({$urandom, $urandom}, {$urandom, $urandom}, "after_ack");
    endtask

    task automatic test_reset_mid_tx();
        int budget;
        int l0;
        send_block({$urandom, $urandom, $urandom, $urandom});
        budget = 0;
        while (UART_TX !== 1'b0 && budget < 2000) begin
            @(negedge CLK_IN);
            budget++;
        end
        total++;
        if (UART_TX !== 1'b0) begin
            bad++;
            $display("FAIL tx_start: got %b want 0 within budget", UART_TX);
        end
        repeat (CPB * 3) @(negedge CLK_IN);
        resetIn = 1'b0;
        #1;
        total++;
        if (UART_TX !== 1'b1) begin
            bad++;
            $display("FAIL tx_abort: got %b want 1", UART_TX);
        end
        repeat (3) @(negedge CLK_IN);
        resetIn = 1'b1;
        l0 = tx_low_cnt;
        repeat (CPB * 20) @(negedge CLK_IN);
        total++;
        if (tx_low_cnt != l0) begin
            bad++;
            $display("FAIL tx_after_abort: got %0d low cycles want 0", tx_low_cnt - l0);
        end
        run_block({$urandom, $urandom}, {$urandom, $urandom}, "after_tx_abort");
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_random();
        test_framing();
        test_reset_mid_block();
        test_wait_ack();
        test_reset_mid_tx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
